// File: rtl/abus_pkg.sv
// Shared abus definitions: handshake state encoding and error-status constants,
// common to the slave endpoint and the master side of the bus.
package abus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } abus_state_e;

    localparam logic ABUS_ERR_NONE = 1'b0;
    localparam logic ABUS_ERR_SET  = 1'b1;

endpackage

// File: rtl/abus_watchdog.sv
// Access watchdog: counts cycles while enabled and flags expiry once the count
// reaches TIMEOUT-1, bounding how long a local access may stall.
module abus_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/abus_slave.sv
// abus slave endpoint: decodes the address window, runs the four-phase req/ack
// handshake and drives a local register port that may insert wait states.
module abus_slave
    import abus_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0100,
    parameter int                    LOCAL_AW   = 8,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  abus_clk,
    input  logic                  abus_rst,
    input  logic                  abus_req,
    output logic                  abus_ack,
    input  logic                  abus_write,
    input  logic                  abus_read,
    input  logic                  abus_abort,
    input  logic [ADDR_WIDTH-1:0] abus_maddress,
    input  logic [DATA_WIDTH-1:0] abus_mwdata,
    output logic [DATA_WIDTH-1:0] abus_srdata,
    output logic                  abus_serr,
    output logic                  loc_wr,
    output logic                  loc_rd,
    output logic [LOCAL_AW-1:0]   loc_addr,
    output logic [DATA_WIDTH-1:0] loc_wdata,
    input  logic [DATA_WIDTH-1:0] loc_rdata,
    input  logic                  loc_ready,
    input  logic                  loc_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    abus_state_e           state_q,  state_d;
    logic                  ack_q,    ack_d;
    logic [DATA_WIDTH-1:0] srdata_q, srdata_d;
    logic                  serr_q,   serr_d;
    logic                  wr_q,     wr_d;
    logic                  rd_q,     rd_d;
    logic [LOCAL_AW-1:0]   addr_q,   addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;

    logic hit;
    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    assign hit = (abus_maddress[ADDR_WIDTH-1:LOCAL_AW] == BASE_ADDR[ADDR_WIDTH-1:LOCAL_AW]);

    abus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk    (abus_clk),
        .rst    (abus_rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        srdata_d = srdata_q;
        serr_d   = serr_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wd_clr   = 1'b1;
        wd_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (abus_req && hit) begin
                    if (abus_write ^ abus_read) begin
                        state_d = ACCESS;
                        addr_d  = abus_maddress[LOCAL_AW-1:0];
                        wdata_d = abus_mwdata;
                        wr_d    = abus_write;
                        rd_d    = abus_read;
                    end else begin
                        // Ambiguous command: answer with an error, never touch the local port.
                        state_d  = ACK;
                        srdata_d = '0;
                        serr_d   = ABUS_ERR_SET;
                    end
                end
            end
            ACCESS: begin
                wd_clr = 1'b0;
                wd_en  = 1'b1;
                if (abus_abort || (!loc_ready && wd_expire)) begin
                    state_d  = ACK;
                    wr_d     = 1'b0;
                    rd_d     = 1'b0;
                    srdata_d = '0;
                    serr_d   = ABUS_ERR_SET;
                end else if (loc_ready) begin
                    state_d  = ACK;
                    wr_d     = 1'b0;
                    rd_d     = 1'b0;
                    srdata_d = rd_q ? loc_rdata : '0;
                    serr_d   = loc_err;
                end
            end
            ACK: begin
                // Ack is raised one cycle after the strobe drops, so the two never overlap.
                if (!abus_req) begin
                    state_d  = IDLE;
                    ack_d    = 1'b0;
                    srdata_d = '0;
                    serr_d   = ABUS_ERR_NONE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge abus_clk or posedge abus_rst) begin
        if (abus_rst) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            srdata_q <= '0;
            serr_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            srdata_q <= srdata_d;
            serr_q   <= serr_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign abus_ack    = ack_q;
    assign abus_srdata = srdata_q;
    assign abus_serr   = serr_q;
    assign loc_wr      = wr_q;
    assign loc_rd      = rd_q;
    assign loc_addr    = addr_q;
    assign loc_wdata   = wdata_q;

endmodule

// File: tb/tb_abus_slave.sv
// Self-checking bench for abus_slave: a driver pushes predicted responses into a
// scoreboard queue, a monitor compares them when the slave acknowledges.
module tb_abus_slave;

    localparam int          AW   = 16;
    localparam int          DW   = 16;
    localparam int          LAW  = 8;
    localparam int          TO   = 16;
    localparam logic [15:0] BASE = 16'h0100;

    logic           clk = 1'b0;
    logic           rst;
    logic           abus_req, abus_ack, abus_write, abus_read, abus_abort;
    logic [AW-1:0]  abus_maddress;
    logic [DW-1:0]  abus_mwdata, abus_srdata;
    logic           abus_serr;
    logic           loc_wr, loc_rd;
    logic [LAW-1:0] loc_addr;
    logic [DW-1:0]  loc_wdata, loc_rdata;
    logic           loc_ready, loc_err;

    abus_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (BASE),
        .LOCAL_AW   (LAW),
        .TIMEOUT    (TO)
    ) dut (
        .abus_clk      (clk),
        .abus_rst      (rst),
        .abus_req      (abus_req),
        .abus_ack      (abus_ack),
        .abus_write    (abus_write),
        .abus_read     (abus_read),
        .abus_abort    (abus_abort),
        .abus_maddress (abus_maddress),
        .abus_mwdata   (abus_mwdata),
        .abus_srdata   (abus_srdata),
        .abus_serr     (abus_serr),
        .loc_wr        (loc_wr),
        .loc_rd        (loc_rd),
        .loc_addr      (loc_addr),
        .loc_wdata     (loc_wdata),
        .loc_rdata     (loc_rdata),
        .loc_ready     (loc_ready),
        .loc_err       (loc_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  srdata;
        logic           serr;
        int             strobes;
        logic           is_wr;
        logic [LAW-1:0] addr;
        logic [DW-1:0]  wdata;
        int             start;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int strobe_total = 0;

    int            cur_delay = 0;
    int            cur_abort = 0;
    logic [DW-1:0] cur_rdata = '0;
    logic          cur_err   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {20'd0, abus_ack, abus_serr, loc_wr, loc_rd, abus_srdata, loc_addr, loc_wdata};
    endfunction

    // Reference: the access ends at whichever comes first of abort, ready or
    // the TIMEOUT-th strobe cycle; abort beats ready, ready beats the timeout.
    function automatic exp_t model(input logic [AW-1:0] addr, input logic wr, input logic rd,
                                   input logic [DW-1:0] wdata, input int delay, input int abort,
                                   input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        int   ready_at;
        e.addr  = addr[LAW-1:0];
        e.wdata = wdata;
        e.is_wr = wr;
        e.start = 0;
        if (wr == rd) begin
            e.strobes = 0; e.serr = 1'b1; e.srdata = '0;
        end else begin
            ready_at = (delay == 0 || delay > TO) ? 0 : delay;
            if (abort != 0 && abort <= ((ready_at == 0) ? TO : ready_at)) begin
                e.strobes = abort; e.serr = 1'b1; e.srdata = '0;
            end else if (ready_at != 0) begin
                e.strobes = ready_at; e.serr = err; e.srdata = rd ? rdata : '0;
            end else begin
                e.strobes = TO; e.serr = 1'b1; e.srdata = '0;
            end
        end
        return e;
    endfunction

    // Monitor: strobe tracking and scoreboard comparison on every rising ack.
    initial begin
        int   str_cnt  = 0;
        logic prev_ack = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                str_cnt  = 0;
                prev_ack = 1'b0;
            end else begin
                if (loc_wr || loc_rd) begin
                    check("strobe_ack_overlap", {63'd0, abus_ack}, 64'd0);
                    if (str_cnt == 0) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_strobe", 64'd1, 64'd0);
                        end else begin
                            check("loc_addr",  {56'd0, loc_addr}, {56'd0, sb_q[0].addr});
                            check("loc_wdata", {48'd0, loc_wdata}, {48'd0, sb_q[0].wdata});
                            check("loc_dir",   {62'd0, loc_wr, loc_rd},
                                  {62'd0, sb_q[0].is_wr, !sb_q[0].is_wr});
                        end
                    end
                    str_cnt++;
                    strobe_total++;
                end
                if (abus_ack && !prev_ack) begin
                    ack_cnt++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_ack", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("srdata",  {48'd0, abus_srdata}, {48'd0, e.srdata});
                        check("serr",    {63'd0, abus_serr}, {63'd0, e.serr});
                        check("strobe_cycles", 64'(str_cnt), 64'(e.strobes));
                        check("ack_latency", 64'(cyc - e.start), 64'(e.strobes + 2));
                    end
                    str_cnt = 0;
                end
                if (prev_ack && !abus_req) begin
                    check("ack_release", {46'd0, abus_ack, abus_serr, abus_srdata}, 64'd0);
                end
                prev_ack = abus_ack;
            end
        end
    end

    // Local responder: raises ready/abort on the programmed strobe cycle.
    initial begin
        int k = 0;
        forever begin
            @(negedge clk);
            #1;
            loc_ready  = 1'b0;
            abus_abort = 1'b0;
            loc_rdata  = DW'($urandom);
            loc_err    = 1'($urandom);
            if (!rst && (loc_wr || loc_rd)) begin
                k++;
                if (k == cur_abort) abus_abort = 1'b1;
                if (k == cur_delay) begin
                    loc_ready = 1'b1;
                    loc_rdata = cur_rdata;
                    loc_err   = cur_err;
                end
            end else begin
                k = 0;
            end
        end
    end

    // rst_mode: 0 normal, 1 reset while acknowledging, 2 reset mid-access.
    task automatic do_txn(input logic [AW-1:0] addr, input logic wr, input logic rd,
                          input logic [DW-1:0] wdata, input int delay, input int abort,
                          input logic [DW-1:0] rdata, input logic err, input int rst_mode);
        exp_t e;
        int   a0, s0;
        bit   seen;
        logic hit;
        hit = (addr[AW-1:LAW] == BASE[AW-1:LAW]);
        cur_delay = delay;
        cur_abort = abort;
        cur_rdata = rdata;
        cur_err   = err;
        @(negedge clk);
        #1;
        abus_req = 1'b1; abus_write = wr; abus_read = rd;
        abus_maddress = addr; abus_mwdata = wdata;
        if (!hit) begin
            a0 = ack_cnt;
            s0 = strobe_total;
            repeat (20) @(negedge clk);
            check("miss_no_ack",    64'(ack_cnt - a0), 64'd0);
            check("miss_no_strobe", 64'(strobe_total - s0), 64'd0);
            #1;
            abus_req = 1'b0; abus_write = 1'b0; abus_read = 1'b0;
            return;
        end
        e = model(addr, wr, rd, wdata, delay, abort, rdata, err);
        e.start = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
        abus_maddress = AW'($urandom);
        abus_mwdata   = DW'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((rst_mode == 2) ? (loc_wr || loc_rd) : abus_ack) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check("ack_timeout", 64'd1, 64'd0);
            rst_mode = 2;
        end
        if (rst_mode != 0) begin
            #1;
            rst = 1'b1;
            #1;
            check("async_reset_outputs", all_outputs(), 64'd0);
            sb_q.delete();
            abus_req = 1'b0; abus_write = 1'b0; abus_read = 1'b0;
            @(negedge clk);
            #1;
            rst = 1'b0;
            return;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        #1;
        abus_req = 1'b0; abus_write = 1'b0; abus_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [AW-1:0] a;
        int            c, d, ab;
        logic          w, r;
        rst = 1'b1;
        abus_req = 1'b0; abus_write = 1'b0; abus_read = 1'b0; abus_abort = 1'b0;
        abus_maddress = '0; abus_mwdata = '0;
        loc_ready = 1'b0; loc_rdata = '0; loc_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", {60'd0, abus_ack, abus_serr, loc_wr, loc_rd}, 64'd0);

        do_txn(16'h0100, 1'b1, 1'b0, 16'hCAFE, 1, 0, 16'h0000, 1'b0, 0);
        do_txn(16'h0104, 1'b0, 1'b1, 16'h1234, 3, 0, 16'hBEEF, 1'b0, 0);
        do_txn(16'h0200, 1'b1, 1'b0, 16'h5555, 1, 0, 16'h0000, 1'b0, 0);
        do_txn(16'h0110, 1'b0, 1'b1, 16'h0000, 0, 0, 16'h0000, 1'b0, 0);
        do_txn(16'h0110, 1'b0, 1'b1, 16'h0000, 2, 2, 16'hA5A5, 1'b0, 0);
        do_txn(16'h0120, 1'b0, 1'b1, 16'h0000, 4, 0, 16'h7E57, 1'b1, 0);
        do_txn(16'h01FF, 1'b1, 1'b0, 16'h0F0F, 16, 0, 16'h0000, 1'b0, 0);
        do_txn(16'h0130, 1'b1, 1'b1, 16'h0000, 1, 0, 16'h0000, 1'b0, 1);
        do_txn(16'h0131, 1'b0, 1'b0, 16'h0000, 1, 0, 16'h0000, 1'b0, 0);
        do_txn(16'h0140, 1'b0, 1'b1, 16'h0000, 0, 0, 16'h0000, 1'b0, 2);
        do_txn(16'h0141, 1'b0, 1'b1, 16'h0000, 2, 0, 16'h1111, 1'b0, 0);

        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 99) < 85) begin
                a = {BASE[AW-1:LAW], 8'($urandom)};
            end else begin
                a = AW'($urandom);
                if (a[AW-1:LAW] == BASE[AW-1:LAW]) a[AW-1] = 1'b1;
            end
            c = $urandom_range(0, 9);
            if (c == 0) begin
                w = 1'($urandom); r = w;
            end else begin
                w = (c < 5); r = !w;
            end
            d  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 18);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
            do_txn(a, w, r, DW'($urandom), d, ab, DW'($urandom), 1'($urandom), 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
